// File: rtl/control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, opcodes,
// ALU CONTROL codes and the control output bundle.
package control_unit_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [4:0] OP_LD    = 5'b00000;
   localparam logic [4:0] OP_ST    = 5'b00010;
   localparam logic [4:0] OP_ADD   = 5'b00011;
   localparam logic [4:0] OP_RLAST = 5'b01011;
   localparam logic [4:0] OP_ADDI  = 5'b01100;
   localparam logic [4:0] OP_ANDI  = 5'b01101;
   localparam logic [4:0] OP_ORI   = 5'b01110;
   localparam logic [4:0] OP_BR    = 5'b10010;
   localparam logic [4:0] OP_NOP   = 5'b11010;
   localparam logic [4:0] OP_HALT  = 5'b11011;

   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_AND  = 5'b00101;
   localparam logic [4:0] ALU_OR   = 5'b00110;

   typedef enum logic [2:0] {
      CLS_NOP, CLS_RTYPE, CLS_IMM, CLS_LD, CLS_ST, CLS_BR, CLS_HALT
   } iclass_t;

   typedef struct packed {
      logic       pc_out;
      logic       mdr_out;
      logic       zhi_out;
      logic       zlo_out;
      logic       hi_out;
      logic       lo_out;
      logic       c_out;
      logic       pc_in;
      logic       mdr_in;
      logic       mar_in;
      logic       ir_in;
      logic       y_in;
      logic       zhi_in;
      logic       zlo_in;
      logic       hi_in;
      logic       lo_in;
      logic       inc_pc;
      logic       read;
      logic       write;
      logic       g_ra;
      logic       g_rb;
      logic       g_rc;
      logic       r_in;
      logic       r_out;
      logic       ba_out;
      logic       con_in;
      logic [4:0] control;
      logic       run;
   } ctrl_t;

   // Undefined opcodes fall into CLS_NOP so they retire straight from T3.
   function automatic iclass_t op_class(input logic [4:0] op);
      iclass_t cls;
      cls = CLS_NOP;
      if (op >= OP_ADD && op <= OP_RLAST) begin
         cls = CLS_RTYPE;
      end else begin
         case (op)
            OP_ADDI, OP_ANDI, OP_ORI: cls = CLS_IMM;
            OP_LD:                    cls = CLS_LD;
            OP_ST:                    cls = CLS_ST;
            OP_BR:                    cls = CLS_BR;
            OP_HALT:                  cls = CLS_HALT;
            default:                  cls = CLS_NOP;
         endcase
      end
      return cls;
   endfunction

   function automatic logic [4:0] imm_alu_code(input logic [4:0] op);
      logic [4:0] code;
      case (op)
         OP_ANDI: code = ALU_AND;
         OP_ORI:  code = ALU_OR;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Moore output decode: maps (state, opcode, branch) to the control bundle.
module control_decode
   import control_unit_pkg::*;
(
   input  state_t     state,
   input  logic [4:0] opcode,
   input  logic       branch,
   output ctrl_t      ctrl
);

   iclass_t cls;
   assign cls = op_class(opcode);

   always_comb begin
      ctrl     = '0;
      ctrl.run = (state != S_HALT);
      case (state)
         S_T0: begin
            ctrl.pc_out = 1'b1;
            ctrl.mar_in = 1'b1;
            ctrl.inc_pc = 1'b1;
         end
         S_T1: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
         end
         S_T2: begin
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         S_T3: begin
            case (cls)
               CLS_RTYPE, CLS_IMM: begin
                  ctrl.g_rb  = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.y_in  = 1'b1;
               end
               CLS_LD, CLS_ST: begin
                  ctrl.g_rb   = 1'b1;
                  ctrl.ba_out = 1'b1;
                  ctrl.y_in   = 1'b1;
               end
               CLS_BR: begin
                  ctrl.g_ra   = 1'b1;
                  ctrl.r_out  = 1'b1;
                  ctrl.con_in = 1'b1;
               end
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               CLS_RTYPE: begin
                  ctrl.g_rc    = 1'b1;
                  ctrl.r_out   = 1'b1;
                  ctrl.zlo_in  = 1'b1;
                  ctrl.control = opcode;
               end
               CLS_IMM: begin
                  ctrl.c_out   = 1'b1;
                  ctrl.zlo_in  = 1'b1;
                  ctrl.control = imm_alu_code(opcode);
               end
               CLS_LD, CLS_ST: begin
                  ctrl.c_out   = 1'b1;
                  ctrl.zlo_in  = 1'b1;
                  ctrl.control = ALU_ADD;
               end
               CLS_BR: begin
                  ctrl.pc_out = 1'b1;
                  ctrl.y_in   = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (cls)
               CLS_RTYPE, CLS_IMM: begin
                  ctrl.zlo_out = 1'b1;
                  ctrl.g_ra    = 1'b1;
                  ctrl.r_in    = 1'b1;
               end
               CLS_LD, CLS_ST: begin
                  ctrl.zlo_out = 1'b1;
                  ctrl.mar_in  = 1'b1;
               end
               CLS_BR: begin
                  ctrl.c_out   = 1'b1;
                  ctrl.zlo_in  = 1'b1;
                  ctrl.control = ALU_ADD;
               end
               default: ;
            endcase
         end
         S_T6: begin
            case (cls)
               CLS_LD: begin
                  ctrl.read   = 1'b1;
                  ctrl.mdr_in = 1'b1;
               end
               CLS_ST: begin
                  ctrl.g_ra   = 1'b1;
                  ctrl.r_out  = 1'b1;
                  ctrl.mdr_in = 1'b1;
               end
               CLS_BR: begin
                  ctrl.zlo_out = 1'b1;
                  ctrl.pc_in   = branch;
               end
               default: ;
            endcase
         end
         S_T7: begin
            case (cls)
               CLS_LD: begin
                  ctrl.mdr_out = 1'b1;
                  ctrl.g_ra    = 1'b1;
                  ctrl.r_in    = 1'b1;
               end
               CLS_ST: ctrl.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: state register and next-state logic, with
// output decode delegated to control_decode.
module control_unit
   import control_unit_pkg::*;
(
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        branch,
   input  logic        Mem_Ready,
   input  logic        Stop,
   output logic        PC_Out,
   output logic        MDR_Out,
   output logic        ZHI_Out,
   output logic        ZLO_Out,
   output logic        HI_Out,
   output logic        LO_Out,
   output logic        C_Out,
   output logic        PC_In,
   output logic        MDR_In,
   output logic        MAR_In,
   output logic        IR_In,
   output logic        Y_In,
   output logic        ZHI_In,
   output logic        ZLO_In,
   output logic        HI_In,
   output logic        LO_In,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        G_RA,
   output logic        G_RB,
   output logic        G_RC,
   output logic        R_In,
   output logic        R_Out,
   output logic        BA_Out,
   output logic        conIn,
   output logic [4:0]  CONTROL,
   output logic        Run
);

   state_t     state_reg;
   state_t     state_next;
   state_t     end_state;
   iclass_t    cls;
   logic [4:0] opcode;
   ctrl_t      ctrl;
   logic       unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];
   assign cls       = op_class(opcode);

   // Every path that would re-enter fetch honours a pending pause request.
   assign end_state = Stop ? S_IDLE : S_T0;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: state_next = Stop ? S_IDLE : S_T0;
         S_T0:   state_next = S_T1;
         S_T1:   state_next = Mem_Ready ? S_T2 : S_T1;
         S_T2:   state_next = S_T3;
         S_T3: begin
            case (cls)
               CLS_RTYPE, CLS_IMM, CLS_LD, CLS_ST, CLS_BR: state_next = S_T4;
               CLS_HALT: state_next = S_HALT;
               default:  state_next = end_state;
            endcase
         end
         S_T4: state_next = S_T5;
         S_T5: begin
            case (cls)
               CLS_LD, CLS_ST, CLS_BR: state_next = S_T6;
               default:                state_next = end_state;
            endcase
         end
         S_T6: begin
            case (cls)
               CLS_LD:  state_next = Mem_Ready ? S_T7 : S_T6;
               CLS_ST:  state_next = S_T7;
               default: state_next = end_state;
            endcase
         end
         S_T7: begin
            case (cls)
               CLS_ST:  state_next = Mem_Ready ? end_state : S_T7;
               default: state_next = end_state;
            endcase
         end
         S_HALT: state_next = S_HALT;
         default: state_next = S_T0;
      endcase
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_reg <= S_T0;
      end else begin
         state_reg <= state_next;
      end
   end

   control_decode u_decode (
      .state  (state_reg),
      .opcode (opcode),
      .branch (branch),
      .ctrl   (ctrl)
   );

   assign PC_Out  = ctrl.pc_out;
   assign MDR_Out = ctrl.mdr_out;
   assign ZHI_Out = ctrl.zhi_out;
   assign ZLO_Out = ctrl.zlo_out;
   assign HI_Out  = ctrl.hi_out;
   assign LO_Out  = ctrl.lo_out;
   assign C_Out   = ctrl.c_out;
   assign PC_In   = ctrl.pc_in;
   assign MDR_In  = ctrl.mdr_in;
   assign MAR_In  = ctrl.mar_in;
   assign IR_In   = ctrl.ir_in;
   assign Y_In    = ctrl.y_in;
   assign ZHI_In  = ctrl.zhi_in;
   assign ZLO_In  = ctrl.zlo_in;
   assign HI_In   = ctrl.hi_in;
   assign LO_In   = ctrl.lo_in;
   assign IncPC   = ctrl.inc_pc;
   assign Read    = ctrl.read;
   assign Write   = ctrl.write;
   assign G_RA    = ctrl.g_ra;
   assign G_RB    = ctrl.g_rb;
   assign G_RC    = ctrl.g_rc;
   assign R_In    = ctrl.r_in;
   assign R_Out   = ctrl.r_out;
   assign BA_Out  = ctrl.ba_out;
   assign conIn   = ctrl.con_in;
   assign CONTROL = ctrl.control;
   assign Run     = ctrl.run;

endmodule
